// File: rtl/cordic_arb_pkg.sv
// Shared widths, default watchdog limit and FSM state encoding for cordic_arbiter.
package cordic_arb_pkg;

  localparam int unsigned XY_W_DEF    = 22;
  localparam int unsigned ANG_W_DEF   = 25;
  localparam int unsigned TIMEOUT_DEF = 40;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/cordic_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first set request at or after ptr_i.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  int unsigned      pos;
  logic [IDX_W-1:0] pos_idx;
  logic             found;

  // Walk upward from the pointer with wrap; the first hit wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    pos     = 0;
    pos_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = 32'(ptr_i) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (!found && req_i[pos_idx]) begin
        found          = 1'b1;
        gnt_o[pos_idx] = 1'b1;
        idx_o          = pos_idx;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin sharing of one CORDIC engine among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned XY_W    = XY_W_DEF,
  parameter int unsigned ANG_W   = ANG_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*XY_W-1:0]    req_x,
  input  logic [NUM_REQ*XY_W-1:0]    req_y,
  input  logic [NUM_REQ*ANG_W-1:0]   req_angle,
  output logic [NUM_REQ-1:0]         resp_done,
  output logic                       resp_err,
  output logic [XY_W-1:0]            resp_x,
  output logic [XY_W-1:0]            resp_y,
  output logic [ANG_W-1:0]           resp_angle,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       cordic_start,
  output logic [XY_W-1:0]            cordic_x,
  output logic [XY_W-1:0]            cordic_y,
  output logic [ANG_W-1:0]           cordic_angle,
  input  logic                       cordic_finish,
  input  logic [XY_W-1:0]            cordic_out_x,
  input  logic [XY_W-1:0]            cordic_out_y,
  input  logic [ANG_W-1:0]           cordic_out_angle
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_e             state_q;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q;
  logic [NUM_REQ-1:0] done_d;
  logic [NUM_REQ-1:0] resp_done_q;
  logic [XY_W-1:0]    resp_x_q, resp_y_q, cordic_x_q, cordic_y_q;
  logic [ANG_W-1:0]   resp_angle_q, cordic_angle_q;
  logic               busy_q, cordic_start_q;
  logic [NUM_REQ-1:0] gnt_c;
  logic [IDX_W-1:0]   gnt_idx_c;

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wcnt_q;
  logic             resp_err_q;
  assign resp_err = resp_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign resp_err       = 1'b0;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt_c),
    .idx_o (gnt_idx_c)
  );

  assign rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign done_d   = NUM_REQ'(1) << owner_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      busy_q         <= 1'b0;
      cordic_start_q <= 1'b0;
      cordic_x_q     <= '0;
      cordic_y_q     <= '0;
      cordic_angle_q <= '0;
      resp_done_q    <= '0;
      resp_x_q       <= '0;
      resp_y_q       <= '0;
      resp_angle_q   <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      wcnt_q         <= '0;
      resp_err_q     <= 1'b0;
`endif
    end else begin
      cordic_start_q <= 1'b0;
      resp_done_q    <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|gnt_c) begin
            owner_q        <= gnt_idx_c;
            cordic_x_q     <= req_x[32'(gnt_idx_c)*XY_W +: XY_W];
            cordic_y_q     <= req_y[32'(gnt_idx_c)*XY_W +: XY_W];
            cordic_angle_q <= req_angle[32'(gnt_idx_c)*ANG_W +: ANG_W];
            cordic_start_q <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= ST_START;
          end
        end
        ST_START: begin
`ifdef CORDIC_ARB_TIMEOUT_EN
          wcnt_q  <= '0;
`endif
          state_q <= ST_WAIT;
        end
        // Finish left high by the previous op is cleared by the engine on start.
        ST_WAIT: begin
          if (cordic_finish) begin
            state_q <= ST_CAPTURE;
`ifdef CORDIC_ARB_TIMEOUT_EN
          end else if (wcnt_q == CNT_W'(TIMEOUT)) begin
            resp_x_q     <= '0;
            resp_y_q     <= '0;
            resp_angle_q <= '0;
            resp_err_q   <= 1'b1;
            resp_done_q  <= done_d;
            state_q      <= ST_DONE;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
`endif
          end
        end
        ST_CAPTURE: begin
          resp_x_q     <= cordic_out_x;
          resp_y_q     <= cordic_out_y;
          resp_angle_q <= cordic_out_angle;
`ifdef CORDIC_ARB_TIMEOUT_EN
          resp_err_q   <= 1'b0;
`endif
          resp_done_q  <= done_d;
          state_q      <= ST_DONE;
        end
        ST_DONE: begin
          rr_ptr_q <= rr_ptr_d;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp_done    = resp_done_q;
  assign resp_x       = resp_x_q;
  assign resp_y       = resp_y_q;
  assign resp_angle   = resp_angle_q;
  assign busy         = busy_q;
  assign owner        = owner_q;
  assign cordic_start = cordic_start_q;
  assign cordic_x     = cordic_x_q;
  assign cordic_y     = cordic_y_q;
  assign cordic_angle = cordic_angle_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: engine stub, transaction-level model, directed and random traffic.
module tb_cordic_arbiter;

  localparam int NUM_REQ = 4;
  localparam int XY_W    = 22;
  localparam int ANG_W   = 25;
  localparam int TIMEOUT = 40;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*XY_W-1:0]    req_x, req_y;
  logic [NUM_REQ*ANG_W-1:0]   req_angle;
  logic [NUM_REQ-1:0]         resp_done;
  logic                       resp_err;
  logic [XY_W-1:0]            resp_x, resp_y;
  logic [ANG_W-1:0]           resp_angle;
  logic                       busy;
  logic [$clog2(NUM_REQ)-1:0] owner;
  logic                       cordic_start;
  logic [XY_W-1:0]            cordic_x, cordic_y;
  logic [ANG_W-1:0]           cordic_angle;
  logic                       cordic_finish;
  logic [XY_W-1:0]            cordic_out_x, cordic_out_y;
  logic [ANG_W-1:0]           cordic_out_angle;

  int total = 0;
  int bad   = 0;
  int k_cur = 5;

  always #5 clk = ~clk;

  cordic_arbiter #(.NUM_REQ(NUM_REQ), .XY_W(XY_W), .ANG_W(ANG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y), .req_angle(req_angle),
    .resp_done(resp_done), .resp_err(resp_err), .resp_x(resp_x), .resp_y(resp_y),
    .resp_angle(resp_angle), .busy(busy), .owner(owner), .cordic_start(cordic_start),
    .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_angle(cordic_angle),
    .cordic_finish(cordic_finish), .cordic_out_x(cordic_out_x), .cordic_out_y(cordic_out_y),
    .cordic_out_angle(cordic_out_angle)
  );

  // Engine stub: finish k cycles after start, held until the next start; k=0 never finishes.
  logic [XY_W-1:0]  st_x, st_y;
  logic [ANG_W-1:0] st_a;
  int               st_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_cnt <= 0; cordic_finish <= 1'b0; st_x <= '0; st_y <= '0; st_a <= '0;
    end else if (cordic_start) begin
      st_cnt <= k_cur; cordic_finish <= 1'b0;
      st_x <= cordic_x; st_y <= cordic_y; st_a <= cordic_angle;
    end else if (st_cnt != 0) begin
      st_cnt <= st_cnt - 1;
      if (st_cnt == 1) cordic_finish <= 1'b1;
    end
  end
  assign cordic_out_x     = st_x + XY_W'(1);
  assign cordic_out_y     = st_y + XY_W'(2);
  assign cordic_out_angle = st_a + ANG_W'(3);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: timestamps of grant, first finish and done per operation.
  int               cyc = 0;
  bit               m_act = 1'b0, m_res = 1'b0, m_found;
  int               m_g = 0, m_done = -1, m_owner = 0, m_ptr = 0, m_vown = 0;
  logic [XY_W-1:0]  m_cx, m_cy, m_vcx = '0, m_vcy = '0, m_px, m_py, m_rx = '0, m_ry = '0;
  logic [ANG_W-1:0] m_ca, m_vca = '0, m_pa, m_ra = '0;
  logic             m_perr, m_rerr = 1'b0;
  int               grants[$];
  int               dones_t[$];
  logic [3:0]       dones_v[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_act = 1'b0; m_ptr = 0; m_vown = 0; m_vcx = '0; m_vcy = '0; m_vca = '0;
      m_rx = '0; m_ry = '0; m_ra = '0; m_rerr = 1'b0; m_done = -1;
    end else begin
      if (m_act && cyc == m_g + 1) begin
        m_vown = m_owner; m_vcx = m_cx; m_vcy = m_cy; m_vca = m_ca;
      end
      if (m_act && cyc == m_done) begin
        m_rx = m_px; m_ry = m_py; m_ra = m_pa; m_rerr = m_perr;
      end
      chk("start", 64'(cordic_start), 64'(m_act && cyc == m_g + 1));
      chk("done", 64'(resp_done), (m_act && cyc == m_done) ? 64'(1 << m_owner) : 64'd0);
      chk("busy", 64'(busy), 64'(m_act && cyc > m_g));
      chk("owner", 64'(owner), 64'(m_vown));
      chk("cordic_x", 64'(cordic_x), 64'(m_vcx));
      chk("cordic_y", 64'(cordic_y), 64'(m_vcy));
      chk("cordic_angle", 64'(cordic_angle), 64'(m_vca));
      chk("resp_x", 64'(resp_x), 64'(m_rx));
      chk("resp_y", 64'(resp_y), 64'(m_ry));
      chk("resp_angle", 64'(resp_angle), 64'(m_ra));
      chk("resp_err", 64'(resp_err), 64'(m_rerr));
      if (cordic_start) grants.push_back(int'(owner));
      if (resp_done != 0) begin dones_t.push_back(cyc); dones_v.push_back(resp_done); end
      if (m_act) begin
        if (!m_res && cyc >= m_g + 2) begin
          if (cordic_finish) begin
            m_res = 1'b1; m_done = cyc + 2; m_perr = 1'b0;
            m_px = m_cx + XY_W'(1); m_py = m_cy + XY_W'(2); m_pa = m_ca + ANG_W'(3);
`ifdef CORDIC_ARB_TIMEOUT_EN
          end else if (cyc == m_g + 2 + TIMEOUT) begin
            m_res = 1'b1; m_done = cyc + 1; m_perr = 1'b1;
            m_px = '0; m_py = '0; m_pa = '0;
`endif
          end
        end
        if (cyc == m_done) begin
          m_ptr = (m_owner + 1) % NUM_REQ;
          m_act = 1'b0;
        end
      end else if (req != 0) begin
        m_found = 1'b0;
        for (int o = 0; o < NUM_REQ; o++) begin
          if (!m_found && req[(m_ptr + o) % NUM_REQ]) begin
            m_found = 1'b1; m_owner = (m_ptr + o) % NUM_REQ;
          end
        end
        m_cx = req_x[m_owner*XY_W +: XY_W];
        m_cy = req_y[m_owner*XY_W +: XY_W];
        m_ca = req_angle[m_owner*ANG_W +: ANG_W];
        m_g = cyc; m_act = 1'b1; m_res = 1'b0; m_done = -1;
      end
    end
  end

  task automatic set_ops(input int i, input logic [XY_W-1:0] x, input logic [XY_W-1:0] y,
                         input logic [ANG_W-1:0] a);
    req_x[i*XY_W +: XY_W]      = x;
    req_y[i*XY_W +: XY_W]      = y;
    req_angle[i*ANG_W +: ANG_W] = a;
  endtask

  task automatic wait_idle();
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    chk("idle_wait", 64'(busy), 64'd0);
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int seen;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1; req = '0; req_x = '0; req_y = '0; req_angle = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start", 64'(cordic_start), 64'd0);
    chk("rst_done", 64'(resp_done), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_resp_x", 64'(resp_x), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single request from requester 1, k=5.
    @(posedge clk); #1 set_ops(1, XY_W'(100), XY_W'(7), ANG_W'(11)); req = 4'b0010;
    @(negedge clk);
    @(negedge clk); chk("single_start_c1", 64'(cordic_start), 64'd1);
    repeat (7) @(negedge clk); chk("single_done_c8", 64'(resp_done), 64'd0);
    @(negedge clk);
    chk("single_done_c9", 64'(resp_done), 64'b0010);
    chk("single_x", 64'(resp_x), 64'd101);
    chk("single_y", 64'(resp_y), 64'd9);
    chk("single_angle", 64'(resp_angle), 64'd14);
    wait_idle();

    // Reset while the engine is busy.
    @(posedge clk); #1 set_ops(0, XY_W'(55), XY_W'(66), ANG_W'(77)); req = 4'b0001;
    @(negedge clk);
    repeat (3) @(negedge clk); chk("pre_rst_busy", 64'(busy), 64'd1);
    @(posedge clk); #1 rst = 1'b1; req = '0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_owner", 64'(owner), 64'd0);
    chk("arst_cordic_x", 64'(cordic_x), 64'd0);
    chk("arst_resp_x", 64'(resp_x), 64'd0);
    chk("arst_done", 64'(resp_done), 64'd0);
    repeat (2) @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    repeat (15) begin @(negedge clk); if (resp_done != 0) seen++; end
    chk("no_done_after_rst", 64'(seen), 64'd0);

    // All four requesting continuously from pointer 0.
    grants.delete(); dones_t.delete(); dones_v.delete();
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, XY_W'($urandom), XY_W'($urandom), ANG_W'($urandom));
    req = 4'hF;
    repeat (50) @(negedge clk);
    wait_idle();
    chk("grant_count", 64'(grants.size()), 64'd5);
    chk("done_count", 64'(dones_t.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < grants.size()) chk($sformatf("grant_order%0d", i), 64'(grants[i]), 64'(exp_order[i]));
      if (i < dones_v.size()) chk($sformatf("done_vec%0d", i), 64'(dones_v[i]), 64'(1 << exp_order[i]));
      if (i + 1 < dones_t.size()) chk($sformatf("done_gap%0d", i), 64'(dones_t[i+1] - dones_t[i]), 64'd10);
    end

    // Requester 2 drops in WAIT while requester 3 arrives.
    @(posedge clk); #1 set_ops(2, XY_W'(20), XY_W'(21), ANG_W'(22)); req = 4'b0100;
    @(negedge clk);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 set_ops(3, XY_W'(30), XY_W'(31), ANG_W'(32)); req = 4'b1000;
    @(negedge clk);
    repeat (6) @(negedge clk); chk("drop_done_c9", 64'(resp_done), 64'b0100);
    chk("drop_resp_x", 64'(resp_x), 64'd21);
    repeat (2) @(negedge clk);
    chk("drop_next_start", 64'(cordic_start), 64'd1);
    chk("drop_next_owner", 64'(owner), 64'd3);
    wait_idle();

`ifdef CORDIC_ARB_TIMEOUT_EN
    // Engine never finishes: watchdog returns an error completion.
    k_cur = 0;
    @(posedge clk); #1 set_ops(0, XY_W'(5), XY_W'(6), ANG_W'(7)); req = 4'b0001;
    @(negedge clk);
    repeat (42) @(negedge clk); chk("to_done_c42", 64'(resp_done), 64'd0);
    @(negedge clk);
    chk("to_done_c43", 64'(resp_done), 64'b0001);
    chk("to_err", 64'(resp_err), 64'd1);
    chk("to_resp_x", 64'(resp_x), 64'd0);
    k_cur = 5;
    wait_idle();
`endif

    // Random traffic: operands change only while the requester is idle.
    repeat (2500) begin
      @(posedge clk); #1;
      k_cur = int'($urandom_range(1, 8));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          set_ops(i, XY_W'($urandom), XY_W'($urandom), ANG_W'($urandom));
          req[i] = 1'b1;
        end
      end
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Round-robin scheduler that shares one `cordic_top` rotation engine among `NUM_REQ` requesters. It latches the granted requester's operands and issues a single-cycle `cordic_start`. It waits for the engine's `cordic_finish`, captures the engine's registered results one cycle later, and returns them with a one-hot done pulse. It sits between the requester blocks and the single CORDIC instance and is the only driver of that instance's start and operand inputs.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `XY_W`, 22: x/y operand and result width, signed.
- `ANG_W`, 25: angle width, signed.
- `TIMEOUT`, 40: watchdog limit in cycles spent in WAIT. Used only with `CORDIC_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NUM_REQ: level request. Operands must be stable while `req[i]` is high.
- `req_x` in NUM_REQ*XY_W: flattened operands; slice i belongs to requester i.
- `req_y` in NUM_REQ*XY_W: flattened operands.
- `req_angle` in NUM_REQ*ANG_W: flattened target angles.
- `resp_done` out NUM_REQ: one-hot, one-cycle completion pulse.
- `resp_err` out 1: qualifies `resp_done`; 1 means the operation timed out.
- `resp_x` out XY_W: result bus shared by all requesters.
- `resp_y` out XY_W: result bus shared by all requesters.
- `resp_angle` out ANG_W: result bus shared by all requesters.
- `busy` out 1: high whenever the block is not in IDLE.
- `owner` out clog2(NUM_REQ): index of the current grant.
- `cordic_start` out 1: start pulse to the engine.
- `cordic_x` out XY_W: registered operand to the engine.
- `cordic_y` out XY_W: registered operand to the engine.
- `cordic_angle` out ANG_W: registered operand to the engine.
- `cordic_finish` in 1: engine finish flag. It stays high after completion until the next start.
- `cordic_out_x` in XY_W: engine result.
- `cordic_out_y` in XY_W: engine result.
- `cordic_out_angle` in ANG_W: engine result.

## Operation
- States:
  - IDLE
  - START
  - WAIT
  - CAPTURE
  - DONE
- IDLE:
  - If any `req` bit is set, grant the first set bit at or after `rr_ptr`, searching upward with wrap.
  - Register `owner` and latch the owner's operand slices into `cordic_x/y/angle`.
  - Go to START.
  - If no `req` bit is set, stay in IDLE.
- START: drive `cordic_start`=1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - `cordic_finish` is sampled only in this state. The stale high left from the previous operation is cleared by the engine on the start edge, so it is never seen here.
  - On `cordic_finish`=1, go to CAPTURE.
- CAPTURE:
  - The engine results are valid in this cycle; register them into `resp_*`.
  - Set `resp_err`=0.
  - Go to DONE.
- DONE:
  - `resp_done[owner]`=1 for this cycle only.
  - Set `rr_ptr` to owner+1, wrapping at `NUM_REQ`.
  - Go to IDLE.
- `cordic_x/y/angle` hold their values from grant until the next grant.
- `resp_*` hold their values until the next CAPTURE.
- If a requester drops `req` mid-operation, the operation still completes and the done pulse is still issued to that index.
- A requester holding `req` through DONE is treated as a new request and competes again. Round-robin prevents starvation.
- A `req` change during a non-IDLE state has no effect until IDLE.
- Reset mid-operation:
  - All state returns to reset values immediately; no done pulse is issued.
  - The engine shares `rst`, so both blocks restart consistently.

## Timing
- Reset values:
  - state=IDLE, `rr_ptr`=0, `owner`=0.
  - `cordic_start`=0, `cordic_x/y/angle`=0.
  - `resp_done`=0, `resp_err`=0, `resp_x/y/angle`=0, `busy`=0.
- Cycle timeline, with the grant in IDLE at cycle 0:
  - `cordic_start`=1 at cycle 1.
  - WAIT from cycle 2.
  - If finish is first seen at cycle F: CAPTURE at F+1, `resp_done` at F+2, IDLE at F+3.
- End-to-end latency:
  - Against the engine's first finish at cycle 2+k, `resp_done` is high at cycle 4+k.
  - The shortest next grant is at cycle 5+k.
- `resp_x/y/angle` and `resp_err` are valid in the `resp_done` cycle.

## Configuration
- `CORDIC_ARB_TIMEOUT_EN` defined:
  - A WAIT-cycle counter runs.
  - When it reaches `TIMEOUT` without finish, go to DONE with `resp_err`=1 and `resp_x/y/angle` forced to 0.
  - The engine is not reset. The next START restarts it.
- Not defined:
  - No counter is built and `resp_err` is tied 0.
  - WAIT lasts indefinitely until finish.

## Structure
- Package `cordic_arb_pkg` holds:
  - The `XY_W`/`ANG_W` defaults.
  - The state enum constants: IDLE=0, START=1, WAIT=2, CAPTURE=3, DONE=4.
  - The default `TIMEOUT`.
- Sub-module `rr_arbiter` is a combinational round-robin priority pick from `req` and `rr_ptr`, returning a one-hot grant and its index.
- The FSM, operand mux/latch and result registers live in `cordic_arbiter`.

## Test plan
The bench replaces the engine with a stub that sets finish k cycles after start and returns x+1, y+2, angle+3.
- Single request: `req`=4'b0010, k=5, x=100 → `cordic_start` at cycle 1, `resp_done`=4'b0010 at cycle 9, `resp_x`=101.
- All four requesting continuously from `rr_ptr`=0 → grant order 0,1,2,3,0, with one done pulse per grant.
- Stale finish: stub finish held high from the previous op and cleared on start → no early CAPTURE; latency equals the fresh-op latency.
- Requester 2 drops `req` in WAIT → `resp_done[2]` still pulses; the next grant goes to requester 3 if it is requesting.
- `rst` asserted in WAIT → all outputs go to reset values asynchronously; no `resp_done` is issued.
- Timeout, with `CORDIC_ARB_TIMEOUT_EN` defined, `TIMEOUT`=40 and the stub never finishing → `resp_done` with `resp_err`=1 and `resp_x`=0 at cycle 43.
